// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with wrap or saturate bounds, terminal-count pulse and sticky overflow.
// Define COUNTER_PRESCALE_EN to qualify steps with a divide-by-PRESCALE tick of en.
module counter_updown_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE = 0,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_updown_param: WIDTH out of range");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("counter_updown_param: MAX_VAL out of range");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("counter_updown_param: PRESCALE out of range");
  end

  logic step;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned    PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Tick fires on the PRESCALE-th en cycle itself, so the step lands on that edge.
  always_comb begin
    step  = en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = step ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step = en;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   count_ext, inc_ext, load_ext;
  logic             at_max, at_min;

  // One extra bit keeps count+1 from aliasing to 0 when MAX_VAL is all ones.
  assign count_ext = {1'b0, count_q};
  assign inc_ext   = count_ext + (WIDTH+1)'(1);
  assign load_ext  = {1'b0, load_val};
  assign at_max    = inc_ext > MAX_EXT;
  assign at_min    = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = (load_ext > MAX_EXT) ? MAX_CNT : load_val;
    end else if (step) begin
      if (dir) begin
        if (at_max) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_min) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_CNT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed bench for counter_updown_param: four configurations driven from shared stimulus.
module tb_counter_updown_param;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, en, dir, load, clr_ovf;
  logic [7:0] load_val;
  logic [7:0] c0, c1, c2, c3;
  logic       tc0, tc1, tc2, tc3;
  logic       ovf0, ovf1, ovf2, ovf3;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  counter_updown_param u0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(c0), .tc(tc0), .ovf(ovf0));

  counter_updown_param #(.MAX_VAL(9), .SATURATE(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(c1), .tc(tc1), .ovf(ovf1));

  counter_updown_param #(.MAX_VAL(9), .SATURATE(1)) u2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(c2), .tc(tc2), .ovf(ovf2));

  counter_updown_param #(.MAX_VAL(150)) u3 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(c3), .tc(tc3), .ovf(ovf3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualified step: en held for as many cycles as the prescaler needs.
  task automatic step_n();
    en = 1'b1;
    repeat (PS) tick();
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; clr_ovf = 1'b0; load_val = '0;
    tick();
    tick();
    chk("rst_count", c0, 0);
    chk("rst_tc", tc0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_count_u1", c1, 0);

    // Up count from reset
    reset = 1'b0;
    dir   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step_n();
      chk("up_count", c0, i);
      chk("up_tc", tc0, 0);
    end
    en = 1'b0;

    // Asynchronous reset between edges at count 37
    do_load(8'd37);
    chk("load37", c0, 37);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", c0, 0);
    chk("async_rst_tc", tc0, 0);
    #1 reset = 1'b0;
    step_n();
    chk("restart_count", c0, 1);
    en = 1'b0;

    // Down count and wrap below zero at full-width MAX_VAL
    dir = 1'b0;
    step_n();
    chk("down_count", c0, 0);
    chk("down_tc", tc0, 0);
    step_n();
    chk("down_wrap_count", c0, 255);
    chk("down_wrap_tc", tc0, 1);
    chk("down_wrap_ovf", ovf0, 1);
    en = 1'b0;

    // Load clamp and up wrap at MAX_VAL=2**WIDTH-1 and MAX_VAL=150
    do_load(8'd255);
    chk("load255_u0", c0, 255);
    chk("load_clamp_u3", c3, 150);
    dir = 1'b1;
    step_n();
    chk("wrap_full_count", c0, 0);
    chk("wrap_full_tc", tc0, 1);
    chk("wrap150_count", c3, 0);
    chk("wrap150_tc", tc3, 1);
    en = 1'b0;

    // Load and en together: load wins, no step
    load_val = 8'd7; load = 1'b1; en = 1'b1; dir = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    chk("load_wins_count", c3, 7);
    chk("load_wins_tc", tc3, 0);
    do_load(8'd200);
    chk("load200_clamp", c3, 150);

    // Wrap mode, MAX_VAL=9
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("u1_ovf_cleared", ovf1, 0);
    do_load(8'd9);
    chk("u1_load9", c1, 9);
    dir = 1'b1;
    step_n();
    chk("u1_wrap_count", c1, 0);
    chk("u1_wrap_tc", tc1, 1);
    chk("u1_wrap_ovf", ovf1, 1);
    en = 1'b0;
    tick();
    chk("u1_tc_one_cycle", tc1, 0);
    chk("u1_ovf_sticky", ovf1, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("u1_clr_ovf", ovf1, 0);
    dir = 1'b0; clr_ovf = 1'b1;
    step_n();
    clr_ovf = 1'b0; en = 1'b0;
    chk("u1_down_wrap_count", c1, 9);
    chk("u1_set_clr_coincide", ovf1, 1);

    // Saturate mode, MAX_VAL=9
    clr_ovf = 1'b1;
    do_load(8'd0);
    clr_ovf = 1'b0;
    chk("u2_load0", c2, 0);
    chk("u2_ovf_clear", ovf2, 0);
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_n();
      chk("u2_sat_low_count", c2, 0);
      chk("u2_sat_low_tc", tc2, 1);
      chk("u2_sat_low_ovf", ovf2, 1);
    end
    en = 1'b0;
    tick();
    chk("u2_tc_drop", tc2, 0);
    do_load(8'd9);
    dir = 1'b1;
    step_n();
    en = 1'b0;
    chk("u2_sat_high_count", c2, 9);
    chk("u2_sat_high_tc", tc2, 1);

    // Enable qualification over 12 en cycles
    do_load(8'd0);
    dir = 1'b1;
    en  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("en_cycle_count", c0, i / PS);
    end
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
